// File: rtl/fp32_pkg.sv
// Shared binary32 constants, op encodings and field helpers for the fp32 arithmetic unit.
package fp32_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'd255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } fp_op_e;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp32_lzc24.sv
// 24-bit leading-zero counter used to renormalise the add/sub difference.
module fp32_lzc24 (
  input  logic [23:0] i_data,
  output logic [4:0]  o_count
);

  // Scan LSB to MSB so the highest set bit makes the final assignment.
  always_comb begin
    // NOTE: default before the loop keeps every path assigned, so no latch is inferred.
    o_count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (i_data[i]) o_count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp32_addsub_mul.sv
// Registered binary32 add/subtract/multiply, flush-to-zero inputs, truncating rounding,
// one operation per clock with a single cycle of latency.
module fp32_addsub_mul
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        exception
);

  fp_op_e             w_op;
  logic               w_a_sign, w_b_sign_eff;
  logic [7:0]         w_a_exp, w_b_exp;
  logic [23:0]        w_a_mant, w_b_mant;
  logic               w_a_zero, w_b_zero, w_special;
  logic               w_a_ge_b;
  logic               w_l_sign, w_s_sign;
  logic [7:0]         w_l_exp, w_s_exp, w_exp_diff;
  logic [23:0]        w_l_mant, w_s_mant, w_s_shift;
  logic [24:0]        w_mag_sum;
  logic [23:0]        w_mag_diff;
  logic [4:0]         w_lzc;
  logic signed [9:0]  w_add_exp;
  logic [23:0]        w_add_mant;
  logic [31:0]        w_add_res;
  logic               w_add_exc;
  logic [24:0]        w_mul_top;
  logic               w_mul_sign;
  logic signed [9:0]  w_mul_exp;
  logic [22:0]        w_mul_frac;
  logic [31:0]        w_mul_res;
  logic               w_mul_exc;
  logic [31:0]        w_res;
  logic               w_exc;
  logic               r_out_valid;
  logic [31:0]        r_result;
  logic               r_exception;

  // Operand decode; exponent 0 means the operand is treated as a signed zero.
  assign w_op         = fp_op_e'(op);
  assign w_a_sign     = fp_sign(a_operand);
  assign w_b_sign_eff = fp_sign(b_operand) ^ (w_op == OP_SUB);
  assign w_a_exp      = fp_exp(a_operand);
  assign w_b_exp      = fp_exp(b_operand);
  assign w_a_mant     = {1'b1, fp_frac(a_operand)};
  assign w_b_mant     = {1'b1, fp_frac(b_operand)};
  assign w_a_zero     = (w_a_exp == 8'd0);
  assign w_b_zero     = (w_b_exp == 8'd0);
  assign w_special    = (w_a_exp == EXP_MAX) || (w_b_exp == EXP_MAX) || (w_op == OP_RSV);

  // Order by magnitude (exponent then mantissa) and align the smaller operand.
  assign w_a_ge_b   = {w_a_exp, w_a_mant} >= {w_b_exp, w_b_mant};
  assign w_l_sign   = w_a_ge_b ? w_a_sign     : w_b_sign_eff;
  assign w_s_sign   = w_a_ge_b ? w_b_sign_eff : w_a_sign;
  assign w_l_exp    = w_a_ge_b ? w_a_exp      : w_b_exp;
  assign w_s_exp    = w_a_ge_b ? w_b_exp      : w_a_exp;
  assign w_l_mant   = w_a_ge_b ? w_a_mant     : w_b_mant;
  assign w_s_mant   = w_a_ge_b ? w_b_mant     : w_a_mant;
  assign w_exp_diff = w_l_exp - w_s_exp;
  assign w_s_shift  = (w_exp_diff >= 8'd24) ? 24'd0 : (w_s_mant >> w_exp_diff);
  assign w_mag_sum  = {1'b0, w_l_mant} + {1'b0, w_s_shift};
  assign w_mag_diff = w_l_mant - w_s_shift;

  fp32_lzc24 u_lzc (
    .i_data  (w_mag_diff),
    .o_count (w_lzc)
  );

  // Add/subtract path: zero shortcuts, far-operand bypass, then sum or normalised difference.
  always_comb begin
    w_add_res  = '0;
    w_add_exc  = 1'b0;
    w_add_exp  = '0;
    w_add_mant = '0;
    if (w_a_zero && w_b_zero) begin
      w_add_res = {w_a_sign & w_b_sign_eff, 31'd0};
    end else if (w_a_zero) begin
      w_add_res = {w_b_sign_eff, b_operand[30:0]};
    end else if (w_b_zero) begin
      w_add_res = a_operand;
    end else if (w_exp_diff >= 8'd24) begin
      w_add_res = {w_l_sign, w_l_exp, w_l_mant[22:0]};
    end else begin
      if (w_l_sign == w_s_sign) begin
        if (w_mag_sum[24]) begin
          w_add_exp  = $signed({2'b00, w_l_exp}) + 10'sd1;
          w_add_mant = w_mag_sum[24:1];
        end else begin
          w_add_exp  = $signed({2'b00, w_l_exp});
          w_add_mant = w_mag_sum[23:0];
        end
      end else begin
        w_add_exp  = $signed({2'b00, w_l_exp}) - $signed({5'd0, w_lzc});
        w_add_mant = w_mag_diff << w_lzc;
      end
      // Exact cancellation always yields +0, whatever the operand signs.
      if (w_add_mant == 24'd0) begin
        w_add_res = '0;
      end else if (w_add_exp >= $signed({2'b00, EXP_MAX})) begin
        w_add_res = POS_INF | {w_l_sign, 31'd0};
        w_add_exc = 1'b1;
      end else if (w_add_exp <= 10'sd0) begin
        w_add_res = {w_l_sign, 31'd0};
      end else begin
        w_add_res = {w_l_sign, w_add_exp[7:0], w_add_mant[22:0]};
      end
    end
  end

  // Only product bits 47:23 are ever kept, so drop the rest at the multiplier.
  assign w_mul_top  = 25'((48'(w_a_mant) * 48'(w_b_mant)) >> 23);
  assign w_mul_sign = fp_sign(a_operand) ^ fp_sign(b_operand);

  // Multiply path: biased exponent sum at 10-bit signed width, one-bit normalisation.
  always_comb begin
    w_mul_res  = '0;
    w_mul_exc  = 1'b0;
    w_mul_exp  = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - $signed(10'(EXP_BIAS));
    w_mul_frac = w_mul_top[22:0];
    if (w_mul_top[24]) begin
      w_mul_exp  = w_mul_exp + 10'sd1;
      w_mul_frac = w_mul_top[23:1];
    end
    if (w_a_zero || w_b_zero) begin
      w_mul_res = {w_mul_sign, 31'd0};
    end else if (w_mul_exp >= $signed({2'b00, EXP_MAX})) begin
      w_mul_res = POS_INF | {w_mul_sign, 31'd0};
      w_mul_exc = 1'b1;
    end else if (w_mul_exp <= 10'sd0) begin
      w_mul_res = {w_mul_sign, 31'd0};
    end else begin
      w_mul_res = {w_mul_sign, w_mul_exp[7:0], w_mul_frac};
    end
  end

  // Select the result by op; Inf/NaN operands and the reserved op force a quiet NaN.
  always_comb begin
    w_res = w_add_res;
    w_exc = w_add_exc;
    if (w_special) begin
      w_res = QNAN;
      w_exc = 1'b1;
    end else if (w_op == OP_MUL) begin
      w_res = w_mul_res;
      w_exc = w_mul_exc;
    end
  end

  // Output register: reset wins, result/exception hold while no operation is issued.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result    <= w_res;
        r_exception <= w_exc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign exception = r_exception;

endmodule

// File: tb/tb_fp32_addsub_mul.sv
// Scoreboard bench for fp32_addsub_mul: stimulus pushes expected results, a monitor
// on the falling edge pops and compares them, and also checks valid timing and hold.
module tb_fp32_addsub_mul;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic [31:0] result;
  logic        exception;

  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic        exp_v   = 1'b0;
  logic        exp_rst = 1'b1;
  logic [31:0] held_res = '0;
  logic        held_exc = 1'b0;

  fp32_addsub_mul dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .result    (result),
    .exception (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = mantissa * 2^exp; truncate to 24 significant bits, then range-check.
  function automatic void pack_norm(input bit sign, input int exp_base, input longint mag,
                                    input int ref_bit, output logic [31:0] r, output logic e);
    int     k;
    int     ex;
    longint frac;
    k = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) k = i;
    ex   = exp_base + k - ref_bit;
    frac = (k >= 23) ? (mag >> (k - 23)) : (mag << (23 - k));
    e    = 1'b0;
    if (ex >= 255) begin
      r = {sign, 31'h7F80_0000};
      e = 1'b1;
    end else if (ex <= 0) begin
      r = {sign, 31'd0};
    end else begin
      r = {sign, 8'(ex), 23'(frac)};
    end
  endfunction

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic e);
    int     ea, eb, el, es, d;
    longint ma, mb, ml, ms, v;
    bit     sa, sbe, sl, ss;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r  = 32'h7FC0_0000;
    e  = 1'b1;
    if (ea == 255 || eb == 255 || o == 2'b11) return;
    e  = 1'b0;
    ma = (ea == 0) ? 64'd0 : longint'({1'b1, a[22:0]});
    mb = (eb == 0) ? 64'd0 : longint'({1'b1, b[22:0]});
    sa = a[31];
    if (o == 2'b10) begin
      sl = a[31] ^ b[31];
      if (ma == 0 || mb == 0) begin
        r = {sl, 31'd0};
        return;
      end
      pack_norm(sl, ea + eb - 127, ma * mb, 46, r, e);
      return;
    end
    sbe = b[31] ^ (o == 2'b01);
    if (ma == 0 && mb == 0) begin r = {sa & sbe, 31'd0}; return; end
    if (ma == 0) begin r = {sbe, b[30:0]}; return; end
    if (mb == 0) begin r = a; return; end
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; ml = ma; sl = sa;  es = eb; ms = mb; ss = sbe;
    end else begin
      el = eb; ml = mb; sl = sbe; es = ea; ms = ma; ss = sa;
    end
    d = el - es;
    if (d >= 24) begin
      r = {sl, 8'(el), 23'(ml)};
      return;
    end
    ms = ms >> d;
    v  = (sl ? -ml : ml) + (ss ? -ms : ms);
    if (v == 0) begin
      r = '0;
      return;
    end
    pack_norm(v < 0, el, (v < 0) ? -v : v, 23, r, e);
  endfunction

  function automatic logic [31:0] rand_fp(input int base);
    int e;
    int sel;
    sel = int'($urandom_range(0, 11));
    case (sel)
      0:       e = 0;
      1:       e = 255;
      2:       e = int'($urandom_range(1, 254));
      3:       e = ($urandom_range(0, 1) == 1) ? 254 : 1;
      default: begin
        e = base + int'($urandom_range(0, 30)) - 15;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
      end
    endcase
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  task automatic issue_rand(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    @(negedge clk);
    in_valid  = 1'b1;
    op        = o;
    a_operand = a;
    b_operand = b;
    ref_model(o, a, b, x.res, x.exc);
    sb_q.push_back(x);
  endtask

  task automatic issue_chk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic e);
    exp_t x;
    @(negedge clk);
    in_valid  = 1'b1;
    op        = o;
    a_operand = a;
    b_operand = b;
    x.res = r;
    x.exc = e;
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      op        = 2'($urandom);
      a_operand = $urandom;
      b_operand = $urandom;
    end
  endtask

  // Expected valid and reset, one cycle behind the driven inputs.
  always @(posedge clk) begin
    exp_v   <= in_valid && !reset;
    exp_rst <= reset;
  end

  // Monitor: valid timing every cycle, scoreboard compare on valid, hold check otherwise.
  always @(negedge clk) begin
    exp_t x;
    if (exp_rst) begin
      held_res = '0;
      held_exc = 1'b0;
    end
    n_vec++;
    if (out_valid !== exp_v) begin
      n_fail++;
      $display("FAIL out_valid @%0t: got %b, want %b", $time, out_valid, exp_v);
    end
    if (out_valid === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output @%0t: got res=%h exc=%b, want no output",
                 $time, result, exception);
      end else begin
        x = sb_q.pop_front();
        if (result !== x.res || exception !== x.exc) begin
          n_fail++;
          $display("FAIL result @%0t: got res=%h exc=%b, want res=%h exc=%b",
                   $time, result, exception, x.res, x.exc);
        end
        held_res = x.res;
        held_exc = x.exc;
      end
    end else begin
      n_vec++;
      if (result !== held_res || exception !== held_exc) begin
        n_fail++;
        $display("FAIL hold @%0t: got res=%h exc=%b, want res=%h exc=%b",
                 $time, result, exception, held_res, held_exc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its end, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int          base, sel;

    // Reset held with in_valid high: outputs must stay cleared.
    reset     = 1'b1;
    in_valid  = 1'b1;
    op        = 2'b00;
    a_operand = 32'h3F80_0000;
    b_operand = 32'h4000_0000;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;

    // Directed cases.
    issue_chk(2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    issue_chk(2'b01, 32'h4040_0000, 32'h40A0_0000, 32'hC000_0000, 1'b0);
    issue_chk(2'b01, 32'h4120_0000, 32'h4120_0000, 32'h0000_0000, 1'b0);
    issue_chk(2'b10, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    issue_chk(2'b10, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0);
    issue_chk(2'b10, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1);
    issue_chk(2'b00, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
    issue_chk(2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
    issue_chk(2'b00, 32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 1'b0);
    issue_chk(2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0);
    issue_chk(2'b00, 32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001, 1'b0);
    issue_chk(2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
    issue_chk(2'b10, 32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 1'b0);
    issue_chk(2'b01, 32'h80C0_0000, 32'h8080_0000, 32'h8000_0000, 1'b0);
    issue_chk(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue_chk(2'b01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    issue_chk(2'b00, 32'h0000_0001, 32'hBF80_0000, 32'hBF80_0000, 1'b0);

    // Back-to-back stream with a one-cycle gap in the third slot.
    issue_chk(2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    issue_chk(2'b10, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
    idle(1);
    issue_chk(2'b01, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 1'b0);
    issue_chk(2'b10, 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b0);
    idle(2);

    // Reset mid-stream with in_valid high clears a nonzero held result.
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b1;
    op        = 2'b10;
    a_operand = 32'h4040_0000;
    b_operand = 32'h4040_0000;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(1);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      sel = int'($urandom_range(0, 15));
      if (sel <= 4)       o = 2'b00;
      else if (sel <= 9)  o = 2'b01;
      else if (sel <= 14) o = 2'b10;
      else                o = 2'b11;
      if (o == 2'b10) begin
        base = 127 + int'($urandom_range(0, 40)) - 20;
        a    = rand_fp(base);
        b    = rand_fp(254 - base);
      end else begin
        base = int'($urandom_range(1, 254));
        a    = rand_fp(base);
        if ($urandom_range(0, 5) == 0)
          b = {1'($urandom_range(0, 1)), a[30:0] ^ 31'($urandom_range(0, 255))};
        else
          b = rand_fp(int'(a[30:23]));
      end
      if ($urandom_range(0, 7) == 0) idle(1);
      issue_rand(o, a, b);
    end
    idle(3);

    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
